// File: rtl/rv_multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I control FSM (master) and its datapath (slave).
// The master modport drives the memory handshake, register enables, mux selects and debug/perf outputs.
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             pc_we;
    logic             oldpc_we;
    logic             ir_we;
    logic             reg_we;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             halt;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, adr_src, pc_we, oldpc_we, ir_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src, halt, state_o,
               cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, adr_src, pc_we, oldpc_we, ir_we, reg_we,
               alu_src_a, alu_src_b, alu_op, result_src, halt, state_o,
               cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal; illegal -> sticky HALT).
// Optional performance counters are built when RV_PERF_CNT_EN is defined.
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    rv_multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic       mem_req_c, mem_we_c, adr_src_c, pc_we_c, oldpc_we_c, ir_we_c, reg_we_c, halt_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
    logic       waiting;

    always_comb begin
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        adr_src_c    = 1'b0;
        pc_we_c      = 1'b0;
        oldpc_we_c   = 1'b0;
        ir_we_c      = 1'b0;
        reg_we_c     = 1'b0;
        halt_c       = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        state_d      = state_q;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                pc_we_c      = bus.mem_ready;
                ir_we_c      = bus.mem_ready;
                oldpc_we_c   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b1100011:             state_d = S_BEQ;
                    7'b1101111:             state_d = S_JAL;
                    default:                state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we_c     = 1'b1;
                result_src_c = 2'b01;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_we_c     = bus.zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_we_c     = 1'b1;
                state_d     = S_ALUWB;
            end
            S_HALT: begin
                halt_c = 1'b1;
            end
            default: state_d = S_HALT;
        endcase

        // A stalled request that has already waited MEM_TIMEOUT cycles gives up on this edge.
        waiting = mem_req_c & ~bus.mem_ready;
        if ((MEM_TIMEOUT > 0) && waiting && (tmo_q == TMO_MAX)) state_d = S_HALT;

        if ((MEM_TIMEOUT == 0) || !waiting || (state_d != state_q)) tmo_d = '0;
        else                                                        tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.mem_req    = reset ? 1'b0  : mem_req_c;
    assign bus.mem_we     = reset ? 1'b0  : mem_we_c;
    assign bus.adr_src    = reset ? 1'b0  : adr_src_c;
    assign bus.pc_we      = reset ? 1'b0  : pc_we_c;
    assign bus.oldpc_we   = reset ? 1'b0  : oldpc_we_c;
    assign bus.ir_we      = reset ? 1'b0  : ir_we_c;
    assign bus.reg_we     = reset ? 1'b0  : reg_we_c;
    assign bus.alu_src_a  = reset ? 2'b00 : alu_src_a_c;
    assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
    assign bus.alu_op     = reset ? 2'b00 : alu_op_c;
    assign bus.result_src = reset ? 2'b00 : result_src_c;
    assign bus.halt       = reset ? 1'b0  : halt_c;
    assign bus.state_o    = reset ? 4'd0  : state_q;

`ifdef RV_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic             retire;

    // An instruction retires on the edge that returns the FSM to FETCH from a final step.
    always_comb begin
        retire = (state_d == S_FETCH) &&
                 ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ));
        cycle_cnt_d   = (state_q == S_HALT) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = retire ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign bus.cycle_cnt   = reset ? '0 : cycle_cnt_q;
    assign bus.instret_cnt = reset ? '0 : instret_cnt_q;
`else
    assign bus.cycle_cnt   = {CNT_W{1'b0}};
    assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed testbench for rv_multicycle_ctrl: one untimed-out instance and one with MEM_TIMEOUT=4.
// Counter expectations follow whether RV_PERF_CNT_EN is defined for the build.
module tb_rv_multicycle_ctrl;

`ifdef RV_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Packed observation: {mem_req,mem_we,adr_src,pc_we,oldpc_we,ir_we,reg_we, a,b,op,rs, halt, state}
    localparam logic [19:0] V_ZERO     = 20'd0;
    localparam logic [19:0] V_FETCH_W  = {7'b1000000, 8'b00100010, 1'b0, 4'd0};
    localparam logic [19:0] V_FETCH_R  = {7'b1001110, 8'b00100010, 1'b0, 4'd0};
    localparam logic [19:0] V_DECODE   = {7'b0000000, 8'b01010000, 1'b0, 4'd1};
    localparam logic [19:0] V_MEMADR   = {7'b0000000, 8'b10010000, 1'b0, 4'd2};
    localparam logic [19:0] V_MEMREAD  = {7'b1010000, 8'b00000000, 1'b0, 4'd3};
    localparam logic [19:0] V_MEMWB    = {7'b0000001, 8'b00000001, 1'b0, 4'd4};
    localparam logic [19:0] V_MEMWRITE = {7'b1110000, 8'b00000000, 1'b0, 4'd5};
    localparam logic [19:0] V_EXEC_R   = {7'b0000000, 8'b10001000, 1'b0, 4'd6};
    localparam logic [19:0] V_EXEC_I   = {7'b0000000, 8'b10011000, 1'b0, 4'd7};
    localparam logic [19:0] V_ALUWB    = {7'b0000001, 8'b00000000, 1'b0, 4'd8};
    localparam logic [19:0] V_BEQ_T    = {7'b0001000, 8'b10000100, 1'b0, 4'd9};
    localparam logic [19:0] V_BEQ_N    = {7'b0000000, 8'b10000100, 1'b0, 4'd9};
    localparam logic [19:0] V_JAL      = {7'b0001000, 8'b01100000, 1'b0, 4'd10};
    localparam logic [19:0] V_HALT     = {7'b0000000, 8'b00000000, 1'b1, 4'd15};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    rv_multicycle_ctrl_if #(.CNT_W(32)) bus_t ();

    rv_multicycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_t (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_t.master)
    );

    function automatic logic [19:0] obs_main();
        return {bus.mem_req, bus.mem_we, bus.adr_src, bus.pc_we, bus.oldpc_we, bus.ir_we,
                bus.reg_we, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                bus.halt, bus.state_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        bus.opcode = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        rst = 1'b1;
        tick();
        got = obs_main();
        checks++;
        if (got !== V_ZERO) begin
            failures++;
            $display("FAIL reset_outputs got=%05h exp=%05h", got, V_ZERO);
        end
        checks++;
        if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.cycle_cnt, bus.instret_cnt);
        end
        rst = 1'b0;
        #1;
        got = obs_main();
        checks++;
        if (got !== V_FETCH_R) begin
            failures++;
            $display("FAIL reset_release_fetch got=%05h exp=%05h", got, V_FETCH_R);
        end
        $display("test_reset done");
    endtask

    task automatic test_rtype();
        logic [28:0] tab [5];
        logic [19:0] got;
        tab = '{ {OP_R, 1'b0, 1'b1, V_FETCH_R}, {OP_R, 1'b0, 1'b1, V_DECODE},
                 {OP_R, 1'b0, 1'b1, V_EXEC_R},  {OP_R, 1'b0, 1'b1, V_ALUWB},
                 {OP_R, 1'b0, 1'b1, V_FETCH_R} };
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            {bus.opcode, bus.zero, bus.mem_ready} = tab[i][28:20];
            #1;
            got = obs_main();
            checks++;
            if (got !== tab[i][19:0]) begin
                failures++;
                $display("FAIL rtype[%0d] got=%05h exp=%05h", i, got, tab[i][19:0]);
            end
            tick();
        end
        checks++;
        if (bus.instret_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL rtype_instret got=%0d exp=%0d", bus.instret_cnt, PERF ? 1 : 0);
        end
        checks++;
        if (bus.cycle_cnt !== (PERF ? 32'd5 : 32'd0)) begin
            failures++;
            $display("FAIL rtype_cycle got=%0d exp=%0d", bus.cycle_cnt, PERF ? 5 : 0);
        end
        $display("test_rtype done");
    endtask

    task automatic test_lw_wait();
        logic [28:0] tab [12];
        logic [19:0] got;
        int          ir_pulses = 0;
        tab = '{ {OP_LW, 1'b0, 1'b0, V_FETCH_W}, {OP_LW, 1'b0, 1'b0, V_FETCH_W},
                 {OP_LW, 1'b0, 1'b0, V_FETCH_W}, {OP_LW, 1'b0, 1'b1, V_FETCH_R},
                 {OP_LW, 1'b0, 1'b1, V_DECODE},  {OP_LW, 1'b0, 1'b1, V_MEMADR},
                 {OP_LW, 1'b0, 1'b0, V_MEMREAD}, {OP_LW, 1'b0, 1'b0, V_MEMREAD},
                 {OP_LW, 1'b0, 1'b0, V_MEMREAD}, {OP_LW, 1'b0, 1'b1, V_MEMREAD},
                 {OP_LW, 1'b0, 1'b1, V_MEMWB},   {OP_LW, 1'b0, 1'b1, V_FETCH_R} };
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            {bus.opcode, bus.zero, bus.mem_ready} = tab[i][28:20];
            #1;
            got = obs_main();
            if (i < 11) ir_pulses += int'(bus.ir_we);
            checks++;
            if (got !== tab[i][19:0]) begin
                failures++;
                $display("FAIL lw_wait[%0d] got=%05h exp=%05h", i, got, tab[i][19:0]);
            end
            tick();
        end
        checks++;
        if (ir_pulses != 1) begin
            failures++;
            $display("FAIL lw_ir_pulses got=%0d exp=1", ir_pulses);
        end
        $display("test_lw_wait done");
    endtask

    task automatic test_back_to_back();
        logic [28:0] tab [19];
        logic [19:0] got;
        tab = '{ {OP_SW,  1'b0, 1'b1, V_FETCH_R}, {OP_SW,  1'b0, 1'b1, V_DECODE},
                 {OP_SW,  1'b0, 1'b1, V_MEMADR},  {OP_SW,  1'b0, 1'b1, V_MEMWRITE},
                 {OP_BEQ, 1'b1, 1'b1, V_FETCH_R}, {OP_BEQ, 1'b1, 1'b1, V_DECODE},
                 {OP_BEQ, 1'b1, 1'b1, V_BEQ_T},
                 {OP_BEQ, 1'b0, 1'b1, V_FETCH_R}, {OP_BEQ, 1'b0, 1'b1, V_DECODE},
                 {OP_BEQ, 1'b0, 1'b1, V_BEQ_N},
                 {OP_I,   1'b1, 1'b1, V_FETCH_R}, {OP_I,   1'b1, 1'b1, V_DECODE},
                 {OP_I,   1'b1, 1'b1, V_EXEC_I},  {OP_I,   1'b1, 1'b1, V_ALUWB},
                 {OP_JAL, 1'b0, 1'b1, V_FETCH_R}, {OP_JAL, 1'b0, 1'b1, V_DECODE},
                 {OP_JAL, 1'b0, 1'b1, V_JAL},     {OP_JAL, 1'b0, 1'b1, V_ALUWB},
                 {OP_R,   1'b0, 1'b1, V_FETCH_R} };
        apply_reset();
        for (int i = 0; i < 19; i++) begin
            {bus.opcode, bus.zero, bus.mem_ready} = tab[i][28:20];
            #1;
            got = obs_main();
            checks++;
            if (got !== tab[i][19:0]) begin
                failures++;
                $display("FAIL b2b[%0d] got=%05h exp=%05h", i, got, tab[i][19:0]);
            end
            tick();
        end
        checks++;
        if (bus.instret_cnt !== (PERF ? 32'd5 : 32'd0)) begin
            failures++;
            $display("FAIL b2b_instret got=%0d exp=%0d", bus.instret_cnt, PERF ? 5 : 0);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_halt();
        logic [19:0] got;
        apply_reset();
        bus.opcode = OP_BAD; bus.zero = 1'b1; bus.mem_ready = 1'b1;
        tick();
        got = obs_main();
        checks++;
        if (got !== V_DECODE) begin
            failures++;
            $display("FAIL halt_decode got=%05h exp=%05h", got, V_DECODE);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            got = obs_main();
            checks++;
            if (got !== V_HALT) begin
                failures++;
                $display("FAIL halt_idle[%0d] got=%05h exp=%05h", i, got, V_HALT);
            end
        end
        checks++;
        if (bus.cycle_cnt !== (PERF ? 32'd2 : 32'd0)) begin
            failures++;
            $display("FAIL halt_cycle_frozen got=%0d exp=%0d", bus.cycle_cnt, PERF ? 2 : 0);
        end
        rst = 1'b1;
        #1;
        got = obs_main();
        checks++;
        if (got !== V_ZERO) begin
            failures++;
            $display("FAIL halt_in_reset got=%05h exp=%05h", got, V_ZERO);
        end
        tick();
        rst = 1'b0;
        #1;
        got = obs_main();
        checks++;
        if (got !== V_FETCH_R) begin
            failures++;
            $display("FAIL halt_recover got=%05h exp=%05h", got, V_FETCH_R);
        end
        $display("test_halt done");
    endtask

    task automatic test_timeout();
        bus.opcode = OP_R; bus.zero = 1'b0;
        bus_t.opcode = OP_R; bus_t.zero = 1'b0;

        // Ready arrives in the last allowed cycle: no timeout.
        bus.mem_ready = 1'b1;
        bus_t.mem_ready = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            bus_t.mem_ready = (k == 4);
            #1;
            checks++;
            if (bus_t.state_o !== 4'd0 || bus_t.halt !== 1'b0) begin
                failures++;
                $display("FAIL tmo_late_ready[%0d] got=%0d exp=0", k, bus_t.state_o);
            end
            tick();
        end
        checks++;
        if (bus_t.state_o !== 4'd1) begin
            failures++;
            $display("FAIL tmo_late_ready_decode got=%0d exp=1", bus_t.state_o);
        end

        // Ready never arrives: HALT on the 5th edge after FETCH entry; untimed instance keeps waiting.
        bus.mem_ready = 1'b0;
        bus_t.mem_ready = 1'b0;
        apply_reset();
        for (int k = 0; k <= 5; k++) begin
            #1;
            checks++;
            if (bus_t.state_o !== ((k < 5) ? 4'd0 : 4'd15) || bus_t.halt !== (k == 5)) begin
                failures++;
                $display("FAIL tmo_expire[%0d] got=%0d halt=%0b exp=%0d", k, bus_t.state_o,
                         bus_t.halt, (k < 5) ? 0 : 15);
            end
            tick();
        end
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (bus.state_o !== 4'd0 || bus.mem_req !== 1'b1 || bus.halt !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_wait got=state%0d req%0b halt%0b exp=state0 req1 halt0",
                     bus.state_o, bus.mem_req, bus.halt);
        end
        bus_t.mem_ready = 1'b1;
        tick();
        checks++;
        if (bus_t.state_o !== 4'd15 || bus_t.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL tmo_sticky got=%0d exp=15", bus_t.state_o);
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        logic [19:0] got;
        bus.opcode = OP_LW; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        got = obs_main();
        checks++;
        if (got !== V_MEMREAD) begin
            failures++;
            $display("FAIL mid_memread got=%05h exp=%05h", got, V_MEMREAD);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.state_o !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_drop got=req%0b state%0d exp=req0 state0", bus.mem_req, bus.state_o);
        end
        tick();
        got = obs_main();
        checks++;
        if (got !== V_ZERO) begin
            failures++;
            $display("FAIL mid_reset_hold got=%05h exp=%05h", got, V_ZERO);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state_o !== 4'd0 || bus.mem_req !== 1'b1 || bus.cycle_cnt !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_release got=state%0d req%0b cyc%0d exp=state0 req1 cyc0",
                     bus.state_o, bus.mem_req, bus.cycle_cnt);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        bus.opcode = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        bus_t.opcode = OP_R; bus_t.zero = 1'b0; bus_t.mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Sequences the 32-bit synchronous-reset state registers (PC, IR, old-PC, data, A/B, ALUOut), the memory request handshake, the register-file write and the datapath muxes.
- Supported subset: lw, sw, R-type, I-type ALU, beq, jal.
- Illegal opcodes park the core in a sticky HALT state until reset.

Parameters:
- MEM_TIMEOUT, 0, max cycles to wait for mem_ready before HALT. 0 = wait forever.
- CNT_W, 32, width of the performance counters (Optional Feature).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled only on posedge clk
- opcode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from datapath
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write (valid only with mem_req)
- adr_src  out  1  0 = PC, 1 = ALUOut drives memory address
- pc_we  out  1  PC register load
- oldpc_we  out  1  old-PC register load
- ir_we  out  1  IR register load
- reg_we  out  1  register-file write
- alu_src_a  out  2  00 PC, 01 old-PC, 10 A register
- alu_src_b  out  2  00 B register, 01 immediate, 10 constant 4
- alu_op  out  2  00 add, 01 sub, 10 decode funct3/funct7
- result_src  out  2  00 ALUOut, 01 data register, 10 ALU result
- halt  out  1  core halted (illegal opcode or timeout)
- state_o  out  4  current state encoding, for debug
- cycle_cnt  out  CNT_W  cycles since reset (Optional Feature)
- instret_cnt  out  CNT_W  retired instructions (Optional Feature)

Behaviour:
- Moore FSM; outputs decode the current state, except that pc_we, ir_we and oldpc_we are also qualified by mem_ready and zero as noted.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, JAL=10, HALT=15.
- Reset: on the reset edge, state <= FETCH and the timeout counter <= 0. While reset is high, every output is forced to 0, including halt and state_o.
- Reset mid-operation (any state, including HALT or a pending memory wait) returns to FETCH on that edge. Any outstanding mem_req is dropped.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Holds while mem_ready=0.
  - In the mem_ready=1 cycle, ir_we=pc_we=oldpc_we=1, then go to DECODE.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ; 1101111 -> JAL; anything else -> HALT.
- MEMADR:
  - Drives alu_src_a=10, alu_src_b=01, alu_op=00.
  - Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_we=1, result_src=01, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Holds until mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: reg_we=1, result_src=00, then FETCH.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_we equals zero in this cycle.
  - Then FETCH.
- JAL:
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_we=1.
  - Then ALUWB, which writes the link address into rd.
- HALT: all outputs 0 except halt=1. Stays in HALT until reset.
- Timeout (MEM_TIMEOUT>0):
  - A counter increments each cycle that mem_req=1 and mem_ready=0, and clears on mem_ready or on a state change.
  - When the counter reaches MEM_TIMEOUT, the FSM goes to HALT on the next edge.
- Outside their listed states, mem_we, reg_we, pc_we, ir_we and oldpc_we are always 0.
- Any output field not listed for a state is 0.

Optional Feature:
- Macro: RV_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every non-reset cycle and wraps modulo 2^CNT_W.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters clear on reset and freeze in HALT.
- Undefined: cycle_cnt and instret_cnt are tied to 0 and no counter flops exist.

Test Plan:
- R-type add (opcode 0110011), mem_ready=1 always.
  - State sequence: FETCH, DECODE, EXEC_R, ALUWB, FETCH (4 cycles/instr).
  - reg_we=1 only in the ALUWB cycle.
  - instret_cnt=1 after it.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD.
  - mem_req stays 1 throughout each wait.
  - ir_we pulses exactly once.
  - Total 5+6=11 cycles to return to FETCH.
- sw then beq: mem_we=1 only in MEMWRITE. beq with zero=1 gives pc_we=1 in BEQ; beq with zero=0 gives pc_we=0.
- Illegal opcode 1111111: DECODE -> HALT. halt=1 for 10 idle cycles with all other outputs 0. Reset gives FETCH with mem_req=1.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: HALT entered on the 5th edge after FETCH entry.
- Reset asserted in MEMREAD while waiting:
  - mem_req=0 and state_o=0 during reset.
  - After release, FETCH with mem_req=1.
  - cycle_cnt restarts at 0 (RV_PERF_CNT_EN defined).
